bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Parametrised multi-master memory-bus arbiter and region decoder. It replaces the hard-wired CPU/OAM-DMA bus multiplexing in the LR35902 top level.
- N masters (CPU, OAM DMA, HDMA, debug port) share four physical regions: external, VRAM, WRAM and OAM.
- Per-region arbitration supports fixed priority or round-robin, burst locking, and a per-master loss policy: stall, or open-bus 0xFF.
- Read data comes back registered, one cycle after acceptance, to match the synchronous RAMs.

Parameters:
- NUM_MASTERS, 3, number of requesting masters; index 0 is the CPU.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- ARB_MODE, 0, 0 = fixed priority (lower index wins), 1 = round-robin per region.
- OPEN_BUS_MASK, 'b001, bit m = 1: master m is acked on a lost arbitration (read returns all-ones, write dropped); 0: master m stalls.

Ports:
- clk  in  1  system clock (4.19 MHz)
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  NUM_MASTERS  request per master
- m_we  in  NUM_MASTERS  1 = write
- m_lock  in  NUM_MASTERS  hold current region after grant (burst)
- m_addr  in  NUM_MASTERS*ADDR_W  flattened addresses
- m_wdata  in  NUM_MASTERS*DATA_W  flattened write data
- m_ack  out  NUM_MASTERS  request accepted this cycle (granted or open-bus)
- m_rvalid  out  NUM_MASTERS  read data valid (one cycle after an accepted read)
- m_rdata  out  NUM_MASTERS*DATA_W  flattened read data
- s_req  out  4  region select (EXT, VRAM, WRAM, OAM)
- s_we  out  4  region write enable
- s_addr  out  4*ADDR_W  per-region address
- s_wdata  out  4*DATA_W  per-region write data
- s_rdata  in  4*DATA_W  per-region synchronous read data, valid the cycle after s_req

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_rvalid = 0, m_rdata = 0.
  - All region owner/lock registers cleared; round-robin pointers = 0; pipeline registers cleared.
  - Combinational outputs (m_ack, s_req, s_we) are 0 while no request is present.
- Decode is combinational, using region_of() from the package:
  - EXT: 0000-7FFF and A000-BFFF.
  - VRAM: 8000-9FFF.
  - WRAM: C000-FDFF (echo area included; s_addr passes the full address).
  - OAM: FE00-FE9F.
  - Anything else: NONE.
- Cycle T, per region:
  - Candidates are the masters with m_req set and region = r.
  - If the region is locked, the owner is the only possible winner. A non-owner candidate loses even if the owner is idle.
  - Otherwise the winner is selected by ARB_MODE.
  - The winner drives s_req/s_we/s_addr/s_wdata[r] and sees m_ack = 1 in cycle T. The write commits at the clk edge ending T.
- Losers in cycle T:
  - OPEN_BUS_MASK = 1: m_ack = 1, no slave access, write discarded, read returns all-ones.
  - OPEN_BUS_MASK = 0: m_ack = 0. The master must hold req, we, addr and wdata stable until acked.
- Region NONE: immediate m_ack; read returns all-ones; write discarded.
- Read return:
  - Cycle T+1: m_rvalid = 1 for one cycle.
  - m_rdata = s_rdata[region registered at T], or all-ones for open-bus/NONE.
  - m_rdata holds its last value when m_rvalid = 0.
  - Back-to-back accepted reads give m_rvalid every cycle.
- Lock:
  - Set at the clk edge when the winner has m_lock = 1.
  - Cleared at the first edge where the owner has m_lock = 0. The owner must still be granted in that cycle.
  - A lock on the NONE region is ignored.
- Round-robin:
  - After each grant on region r, rr_ptr[r] = (winner + 1) mod NUM_MASTERS.
  - The search starts at rr_ptr[r] and wraps.
  - The pointer is frozen while the region is locked.
- Masters requesting different regions in the same cycle are all granted together.
- Reset mid-burst drops the lock. Any read launched in the reset cycle produces no rvalid.

Optional Feature:
- BUS_ARB_STATS_EN
- Defined:
  - Adds a 16-bit saturating counter per master: stall_cnt, incremented each cycle the master is m_req and not m_ack.
  - Adds a 16-bit saturating counter per master: openbus_cnt, incremented for each open-bus ack.
  - Adds output port stats_flat (NUM_MASTERS*32 bits, {openbus_cnt, stall_cnt} per master).
  - Counters clear on reset.
- Not defined: no counters and no stats_flat port.

Decomposition:
- Package bus_arbiter_pkg:
  - Region enum: REG_EXT = 0, REG_VRAM = 1, REG_WRAM = 2, REG_OAM = 3, REG_NONE = 4.
  - NUM_REGIONS = 4.
  - Region boundary constants and function region_of(addr).
  - OPEN_BUS_DATA = all-ones.
- Sub-module region_arb, instantiated once per region:
  - Candidate vector in, winner one-hot plus valid out.
  - Contains the lock/owner register and rr_ptr.

Test Plan:
- CPU (m0) reads 0xC123 with WRAM returning 0x5A → m_ack[0] at T, m_rvalid[0] at T+1, m_rdata0 = 0x5A.
- m0 and m1 both read 0x8000, ARB_MODE = 0 → m0 granted. With OPEN_BUS_MASK = 'b010, m1 is acked with rdata 0xFF at T+1; with 'b000, m1 stalls and is granted at T+1.
- m1 locks OAM and writes FE00-FE9F as a 160-cycle burst while m0 reads FE10 (open-bus) → m0 gets 0xFF every attempt, no OAM write from m0, lock released on the cycle after the last m_lock.
- ARB_MODE = 1, three stalling masters continuously hitting EXT → grants rotate 0, 1, 2, 0 with no master starved beyond 2 cycles.
- Write to 0xFEA0 (NONE) and read from 0xFF80 → immediate ack, no s_req asserted, read data 0xFF.
- Assert rst_n low mid-burst with a read in flight → m_rvalid = 0, lock cleared; after release, m0 accesses the formerly locked region immediately.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ------------------------------------------------------------------
// bus_arbiter_pkg : region encoding, address map and region decoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

  localparam int NUM_REGIONS = 4;

  typedef enum logic [2:0] {
    REG_EXT  = 3'd0,
    REG_VRAM = 3'd1,
    REG_WRAM = 3'd2,
    REG_OAM  = 3'd3,
    REG_NONE = 3'd4
  } region_e;

  localparam logic [15:0] VRAM_BASE   = 16'h8000;
  localparam logic [15:0] EXT_HI_BASE = 16'hA000;
  localparam logic [15:0] WRAM_BASE   = 16'hC000;
  localparam logic [15:0] WRAM_LAST   = 16'hFDFF;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam logic [15:0] OAM_LAST    = 16'hFE9F;

  localparam logic [63:0] OPEN_BUS_DATA = '1;

  // Cartridge space is split around VRAM; WRAM includes its echo mirror.
  function automatic region_e region_of(input logic [15:0] addr);
    if (addr < VRAM_BASE)                         return REG_EXT;
    if (addr < EXT_HI_BASE)                       return REG_VRAM;
    if (addr < WRAM_BASE)                         return REG_EXT;
    if (addr <= WRAM_LAST)                        return REG_WRAM;
    if ((addr >= OAM_BASE) && (addr <= OAM_LAST)) return REG_OAM;
    return REG_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_if.sv
// ------------------------------------------------------------------
// bus_arbiter_if : master-side and region-side bus bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
);

  logic [NUM_MASTERS-1:0]          m_req;
  logic [NUM_MASTERS-1:0]          m_we;
  logic [NUM_MASTERS-1:0]          m_lock;
  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr;
  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata;
  logic [NUM_MASTERS-1:0]          m_ack;
  logic [NUM_MASTERS-1:0]          m_rvalid;
  logic [NUM_MASTERS*DATA_W-1:0]   m_rdata;

  logic [NUM_REGIONS-1:0]          s_req;
  logic [NUM_REGIONS-1:0]          s_we;
  logic [NUM_REGIONS*ADDR_W-1:0]   s_addr;
  logic [NUM_REGIONS*DATA_W-1:0]   s_wdata;
  logic [NUM_REGIONS*DATA_W-1:0]   s_rdata;

  modport arb (
    input  m_req, m_we, m_lock, m_addr, m_wdata, s_rdata,
    output m_ack, m_rvalid, m_rdata, s_req, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_lock, m_addr, m_wdata,
    input  m_ack, m_rvalid, m_rdata
  );

  modport slave (
    input  s_req, s_we, s_addr, s_wdata,
    output s_rdata
  );

endinterface

`default_nettype wire

// File: rtl/bus_arbiter_region_arb.sv
// ------------------------------------------------------------------
// bus_arbiter_region_arb : one-region winner select with burst lock
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bus_arbiter_region_arb #(
  parameter int NUM_MASTERS = 3,
  parameter int ARB_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] cand_i,
  input  logic [NUM_MASTERS-1:0] lock_i,
  output logic [NUM_MASTERS-1:0] win_o,
  output logic                   valid_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic             locked_q, locked_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_idx;

  always_comb begin : p_win
    int idx;
    idx     = 0;
    win_idx = '0;
    win_o   = '0;
    if (locked_q) begin
      // An idle owner still blocks everybody else on this region.
      win_idx        = owner_q;
      win_o[owner_q] = cand_i[owner_q];
    end else if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (cand_i[IDX_W'(i)]) win_idx = IDX_W'(i);
      end
      win_o[win_idx] = |cand_i;
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
        if (cand_i[IDX_W'(idx)]) win_idx = IDX_W'(idx);
      end
      win_o[win_idx] = |cand_i;
    end
    valid_o = |win_o;
  end

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (valid_o) begin
      locked_d = lock_i[win_idx];
      owner_d  = win_idx;
      if (!locked_q) begin
        rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ------------------------------------------------------------------
// bus_arbiter : multi-master region decoder/arbiter, registered reads.
// Optional per-master stall/open-bus counters: BUS_ARB_STATS_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                     NUM_MASTERS   = 3,
  parameter int                     ADDR_W        = 16,
  parameter int                     DATA_W        = 8,
  parameter int                     ARB_MODE      = 0,
  parameter logic [NUM_MASTERS-1:0] OPEN_BUS_MASK = 'b001
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BUS_ARB_STATS_EN
  output logic [NUM_MASTERS*32-1:0] stats_flat,
  bus_arbiter_if.arb                bus
`else
  bus_arbiter_if.arb                bus
`endif
);

  region_e                                   reg_m [NUM_MASTERS];
  logic [NUM_REGIONS-1:0][NUM_MASTERS-1:0]   cand;
  logic [NUM_REGIONS-1:0][NUM_MASTERS-1:0]   win;
  logic [NUM_REGIONS-1:0]                    reg_valid;
  logic [NUM_MASTERS-1:0]                    granted, open_bus, ack, rd_accept;

  logic [NUM_MASTERS-1:0]                    rvalid_q, ob_q;
  logic [NUM_MASTERS-1:0][1:0]               rsel_q;
  logic [NUM_MASTERS-1:0][DATA_W-1:0]        rdata_q, rdata_d;

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      reg_m[m] = region_of(bus.m_addr[m*ADDR_W +: 16]);
      for (int r = 0; r < NUM_REGIONS; r++) begin
        cand[r][m] = bus.m_req[m] && (reg_m[m] == region_e'(r));
      end
    end
  end

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
    bus_arbiter_region_arb #(
      .NUM_MASTERS (NUM_MASTERS),
      .ARB_MODE    (ARB_MODE)
    ) u_region_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .cand_i  (cand[r]),
      .lock_i  (bus.m_lock),
      .win_o   (win[r]),
      .valid_o (reg_valid[r])
    );
  end

  always_comb begin
    bus.s_req   = reg_valid;
    bus.s_we    = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    granted     = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (win[r][m]) begin
          bus.s_we[r]                         = bus.m_we[m];
          bus.s_addr[r*ADDR_W +: ADDR_W]      = bus.m_addr[m*ADDR_W +: ADDR_W];
          bus.s_wdata[r*DATA_W +: DATA_W]     = bus.m_wdata[m*DATA_W +: DATA_W];
          granted[m]                          = 1'b1;
        end
      end
    end
  end

  // Unmapped addresses always complete as open-bus, whatever the master's policy.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      open_bus[m] = bus.m_req[m] && !granted[m]
                    && ((reg_m[m] == REG_NONE) || OPEN_BUS_MASK[m]);
    end
    ack       = granted | open_bus;
    rd_accept = ack & ~bus.m_we;
    bus.m_ack = ack;
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      rdata_d[m] = rdata_q[m];
      if (rvalid_q[m]) begin
        rdata_d[m] = ob_q[m] ? OPEN_BUS_DATA[DATA_W-1:0]
                             : bus.s_rdata[rsel_q[m]*DATA_W +: DATA_W];
      end
    end
    bus.m_rdata  = rdata_d;
    bus.m_rvalid = rvalid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      ob_q     <= '0;
      rsel_q   <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_accept;
      ob_q     <= open_bus;
      rdata_q  <= rdata_d;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        rsel_q[m] <= 2'(reg_m[m]);
      end
    end
  end

`ifdef BUS_ARB_STATS_EN
  logic [NUM_MASTERS-1:0][15:0] stall_cnt_q, openbus_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      openbus_cnt_q <= '0;
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (bus.m_req[m] && !ack[m] && (stall_cnt_q[m] != 16'hFFFF)) begin
          stall_cnt_q[m] <= stall_cnt_q[m] + 16'd1;
        end
        if (open_bus[m] && (openbus_cnt_q[m] != 16'hFFFF)) begin
          openbus_cnt_q[m] <= openbus_cnt_q[m] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      stats_flat[m*32 +: 32] = {openbus_cnt_q[m], stall_cnt_q[m]};
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ------------------------------------------------------------------
// tb_bus_arbiter : directed scoreboard bench, fixed-priority and RR DUTs
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8)) ia ();
  bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8)) ib ();

  // Fixed priority; m0/m1 take open-bus, m2 stalls.
  bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(0),
                .OPEN_BUS_MASK(3'b011)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  // Round-robin; every master stalls on a loss.
  bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(1),
                .OPEN_BUS_MASK(3'b000)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'hC123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] mem_a [0:65535];
  bit         wv_a  [0:65535];
  int         wr_cnt_a [4];
  logic [7:0] mem_b [0:65535];
  bit         wv_b  [0:65535];

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (ia.s_req[r]) begin
        if (ia.s_we[r]) begin
          mem_a[ia.s_addr[r*16 +: 16]] <= ia.s_wdata[r*8 +: 8];
          wv_a[ia.s_addr[r*16 +: 16]]  <= 1'b1;
          wr_cnt_a[r]                  <= wr_cnt_a[r] + 1;
        end else begin
          ia.s_rdata[r*8 +: 8] <= wv_a[ia.s_addr[r*16 +: 16]] ? mem_a[ia.s_addr[r*16 +: 16]]
                                                             : pat(ia.s_addr[r*16 +: 16]);
        end
      end
      if (ib.s_req[r]) begin
        if (ib.s_we[r]) begin
          mem_b[ib.s_addr[r*16 +: 16]] <= ib.s_wdata[r*8 +: 8];
          wv_b[ib.s_addr[r*16 +: 16]]  <= 1'b1;
        end else begin
          ib.s_rdata[r*8 +: 8] <= wv_b[ib.s_addr[r*16 +: 16]] ? mem_b[ib.s_addr[r*16 +: 16]]
                                                             : pat(ib.s_addr[r*16 +: 16]);
        end
      end
    end
  end

  typedef struct {
    bit         dut;
    int         m;
    logic [7:0] d;
  } rd_t;

  rd_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input bit d, input int m, input logic [7:0] v);
    rd_t e;
    e.dut = d;
    e.m   = m;
    e.d   = v;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    logic [2:0] ev_a;
    logic [2:0] ev_b;
    rd_t        e;
    ev_a = '0;
    ev_b = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.dut) begin
        ev_a[e.m] = 1'b1;
        chk("rdata_a", 32'(ia.m_rdata[e.m*8 +: 8]), 32'(e.d));
      end else begin
        ev_b[e.m] = 1'b1;
        chk("rdata_b", 32'(ib.m_rdata[e.m*8 +: 8]), 32'(e.d));
      end
    end
    chk("rvalid_a", 32'(ia.m_rvalid), 32'(ev_a));
    chk("rvalid_b", 32'(ib.m_rvalid), 32'(ev_b));
  endtask

  task automatic edge_rd();
    @(posedge clk);
    #1;
    check_rd();
  endtask

  task automatic set_m(input bit d, input int m, input logic req, input logic we,
                       input logic lock, input logic [15:0] addr, input logic [7:0] wd);
    if (!d) begin
      ia.m_req[m] = req;  ia.m_we[m] = we;  ia.m_lock[m] = lock;
      ia.m_addr[m*16 +: 16] = addr;  ia.m_wdata[m*8 +: 8] = wd;
    end else begin
      ib.m_req[m] = req;  ib.m_we[m] = we;  ib.m_lock[m] = lock;
      ib.m_addr[m*16 +: 16] = addr;  ib.m_wdata[m*8 +: 8] = wd;
    end
  endtask

  task automatic idle_all();
    ia.m_req = '0;  ia.m_we = '0;  ia.m_lock = '0;
    ib.m_req = '0;  ib.m_we = '0;  ib.m_lock = '0;
  endtask

  initial begin
    int wr_before;
    rst_n = 1'b0;
    idle_all();
    ia.m_addr = '0;  ia.m_wdata = '0;
    ib.m_addr = '0;  ib.m_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid_a", 32'(ia.m_rvalid), 0);
    chk("rst_rdata_a",  32'(ia.m_rdata), 0);
    chk("rst_ack_a",    32'(ia.m_ack), 0);
    chk("rst_sreq_a",   32'(ia.s_req), 0);
    chk("rst_rvalid_b", 32'(ib.m_rvalid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single WRAM read by the CPU.
    set_m(0, 0, 1, 0, 0, 16'hC123, 8'h00);
    @(negedge clk);
    chk("t1_ack",   32'(ia.m_ack), 32'b001);
    chk("t1_sreq",  32'(ia.s_req), 32'b0100);
    chk("t1_saddr", 32'(ia.s_addr[2*16 +: 16]), 32'hC123);
    expect_rd(0, 0, 8'h5A);
    edge_rd();
    idle_all();
    @(negedge clk);
    chk("t1_idle_ack", 32'(ia.m_ack), 0);
    edge_rd();
    chk("t1_hold", 32'(ia.m_rdata[7:0]), 32'h5A);

    // m0 and m1 collide on VRAM; m1 takes open-bus.
    set_m(0, 0, 1, 0, 0, 16'h8000, 8'h00);
    set_m(0, 1, 1, 0, 0, 16'h8000, 8'h00);
    @(negedge clk);
    chk("t2_ack",   32'(ia.m_ack), 32'b011);
    chk("t2_sreq",  32'(ia.s_req), 32'b0010);
    expect_rd(0, 0, 8'hBC);
    expect_rd(0, 1, 8'hFF);
    edge_rd();
    idle_all();

    // m0 and m2 collide on VRAM; m2 stalls then wins alone.
    set_m(0, 0, 1, 0, 0, 16'h8001, 8'h00);
    set_m(0, 2, 1, 0, 0, 16'h8002, 8'h00);
    @(negedge clk);
    chk("t3_ack0", 32'(ia.m_ack), 32'b001);
    expect_rd(0, 0, 8'hBD);
    edge_rd();
    set_m(0, 0, 0, 0, 0, 16'h8001, 8'h00);
    @(negedge clk);
    chk("t3_ack1",  32'(ia.m_ack), 32'b100);
    chk("t3_saddr", 32'(ia.s_addr[1*16 +: 16]), 32'h8002);
    expect_rd(0, 2, 8'hBE);
    edge_rd();
    idle_all();

    // m1 locks OAM for a full-table burst while m0 keeps reading FE10.
    for (int i = 0; i < 160; i++) begin
      set_m(0, 1, 1, 1, (i != 159), 16'hFE00 + 16'(i), 8'(i * 3 + 1));
      if (i == 1) set_m(0, 0, 1, 0, 0, 16'hFE10, 8'h00);
      @(negedge clk);
      chk("lk_ack",   32'(ia.m_ack), (i == 0) ? 32'b010 : 32'b011);
      chk("lk_saddr", 32'(ia.s_addr[3*16 +: 16]), 32'(16'hFE00 + 16'(i)));
      chk("lk_swe",   32'(ia.s_we), 32'b1000);
      if (i > 0) expect_rd(0, 0, 8'hFF);
      edge_rd();
    end
    set_m(0, 1, 0, 0, 0, 16'hFE9F, 8'h00);
    @(negedge clk);
    chk("lk_rel_ack",  32'(ia.m_ack), 32'b001);
    chk("lk_rel_sreq", 32'(ia.s_req), 32'b1000);
    chk("lk_rel_swe",  32'(ia.s_we), 32'b0000);
    expect_rd(0, 0, 8'h31);
    edge_rd();
    chk("lk_wr_cnt", 32'(wr_cnt_a[3]), 32'd160);
    idle_all();

    // Unmapped write and read complete immediately without a region access.
    wr_before = wr_cnt_a[0] + wr_cnt_a[1] + wr_cnt_a[2] + wr_cnt_a[3];
    set_m(0, 0, 1, 1, 0, 16'hFEA0, 8'h77);
    set_m(0, 1, 1, 0, 0, 16'hFF80, 8'h00);
    @(negedge clk);
    chk("none_ack",  32'(ia.m_ack), 32'b011);
    chk("none_sreq", 32'(ia.s_req), 0);
    expect_rd(0, 1, 8'hFF);
    edge_rd();
    idle_all();
    chk("none_wr", 32'(wr_cnt_a[0] + wr_cnt_a[1] + wr_cnt_a[2] + wr_cnt_a[3]), 32'(wr_before));

    // Reset in the middle of a WRAM burst with a read in flight.
    set_m(0, 1, 1, 1, 1, 16'hC000, 8'h99);
    @(negedge clk);
    chk("rs_ack0",  32'(ia.m_ack), 32'b010);
    chk("rs_sreq0", 32'(ia.s_req), 32'b0100);
    edge_rd();
    set_m(0, 1, 1, 0, 1, 16'hC001, 8'h00);
    set_m(0, 0, 1, 0, 0, 16'hC000, 8'h00);
    @(negedge clk);
    chk("rs_ack1",   32'(ia.m_ack), 32'b011);
    chk("rs_saddr1", 32'(ia.s_addr[2*16 +: 16]), 32'hC001);
    rst_n = 1'b0;
    edge_rd();
    chk("rs_rdata", 32'(ia.m_rdata), 0);
    idle_all();
    rst_n = 1'b1;
    set_m(0, 0, 1, 0, 0, 16'hC000, 8'h00);
    @(negedge clk);
    chk("rs_ack2",  32'(ia.m_ack), 32'b001);
    chk("rs_sreq2", 32'(ia.s_req), 32'b0100);
    expect_rd(0, 0, 8'h99);
    edge_rd();
    idle_all();

    // Round-robin DUT: stall then grant on a VRAM collision.
    set_m(1, 0, 1, 0, 0, 16'h8000, 8'h00);
    set_m(1, 1, 1, 0, 0, 16'h8000, 8'h00);
    @(negedge clk);
    chk("rr_v_ack0", 32'(ib.m_ack), 32'b001);
    expect_rd(1, 0, 8'hBC);
    edge_rd();
    set_m(1, 0, 0, 0, 0, 16'h8000, 8'h00);
    @(negedge clk);
    chk("rr_v_ack1", 32'(ib.m_ack), 32'b010);
    expect_rd(1, 1, 8'hBC);
    edge_rd();
    idle_all();

    // Three masters hammering EXT must rotate 0, 1, 2, 0, ...
    for (int m = 0; m < 3; m++) set_m(1, m, 1, 0, 0, 16'h0100 + 16'(m), 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_rot_ack", 32'(ib.m_ack), 32'(3'b001 << (i % 3)));
      chk("rr_rot_saddr", 32'(ib.s_addr[0 +: 16]), 32'(16'h0100 + 16'(i % 3)));
      expect_rd(1, i % 3, pat(16'h0100 + 16'(i % 3)));
      edge_rd();
    end
    idle_all();
    @(negedge clk);
    chk("end_ack_b", 32'(ib.m_ack), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
